burst_coalescer: RTL and testbench

Converts a stream of word-aligned read or write addresses into AXI-style bursts, emitted as packed `{burst_len, base_addr}` records. It succeeds the single-stage burst detector and adds four things: a registered output slot with back-pressure, address-boundary splitting (4 KiB by default), stall-free continuation while the output is full, and optional statistics counters. It sits between a kernel's address FIFO and the memory-side request FIFO of the async memory-mapped channel.

---
 rtl/burst_coalescer.sv | 214 +++++++++++++++++++++
 tb/tb_burst_coalescer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_coalescer.sv
// ---------------------------------------------------------------------------
// burst_coalescer
//
// Merges a stream of word-aligned addresses into AXI-style bursts and emits
// packed {burst_len, base_addr} records through a registered output slot.
// burst_len is encoded as beats-1. A burst never crosses a 2^BoundaryLog byte
// boundary, never exceeds max_burst_len, and is flushed after max_wait_time
// idle input cycles. Contiguous addresses keep merging while the output slot
// is full; only a burst-terminating address has to wait for a free slot.
//
// Optional feature macro: BURST_COALESCER_STATS_EN
//   defined   -> stat_bursts / stat_beats counters and ports exist
//   undefined -> no statistics ports or counters
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   synchronous active-high reset
//   max_wait_time  in   idle cycles tolerated before a partial burst flushes
//   max_burst_len  in   cap on burst_len (0 disables merging)
//   addr_dout      in   input address
//   addr_empty_n   in   input address valid
//   addr_read      out  pop the input address
//   burst_din      out  {burst_len, base_addr} record
//   burst_full_n   in   downstream has room
//   burst_write    out  push the record downstream
//   stat_bursts    out  bursts written (stats build only)
//   stat_beats     out  beats written (stats build only)
// ---------------------------------------------------------------------------
module burst_coalescer #(
   parameter int AddrWidth         = 64,
   parameter int DataWidthBytesLog = 6,
   parameter int WaitTimeWidth     = 4,
   parameter int BurstLenWidth     = 8,
   parameter int BoundaryLog       = 12
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [WaitTimeWidth-1:0]           max_wait_time,
   input  logic [BurstLenWidth-1:0]           max_burst_len,
   input  logic [AddrWidth-1:0]               addr_dout,
   input  logic                               addr_empty_n,
   output logic                               addr_read,
   output logic [BurstLenWidth+AddrWidth-1:0] burst_din,
   input  logic                               burst_full_n,
   output logic                               burst_write
`ifdef BURST_COALESCER_STATS_EN
   ,
   output logic [31:0]                        stat_bursts,
   output logic [31:0]                        stat_beats
`endif
);

   localparam int RecWidth = BurstLenWidth + AddrWidth;

   // Coalescing state
   logic [AddrWidth-1:0]     base_addr_r;
   logic                     base_valid_r;
   logic [BurstLenWidth-1:0] burst_len_r;
   logic [WaitTimeWidth-1:0] wait_time_r;

   // Output slot
   logic                     out_valid_r;
   logic [RecWidth-1:0]      out_data_r;

   // Next-state values
   logic [AddrWidth-1:0]     base_addr_s;
   logic                     base_valid_s;
   logic [BurstLenWidth-1:0] burst_len_s;
   logic [WaitTimeWidth-1:0] wait_time_s;
   logic                     out_valid_s;
   logic [RecWidth-1:0]      out_data_s;

   // Decision helpers
   logic [AddrWidth-1:0]     beats_s;
   logic [AddrWidth-1:0]     next_addr_s;
   logic                     same_region_s;
   logic                     extend_s;
   logic                     out_free_s;
   logic                     write_s;
   logic                     read_s;
   logic                     emit_s;

   // Address that would continue the current burst, plus the merge test.
   // The region compare also rejects an all-ones to zero wrap, since the
   // upper bits necessarily differ across such a wrap.
   always_comb begin
      beats_s       = {{(AddrWidth-BurstLenWidth){1'b0}}, burst_len_r}
                      + {{(AddrWidth-1){1'b0}}, 1'b1};
      next_addr_s   = base_addr_r + (beats_s << DataWidthBytesLog);
      same_region_s = (addr_dout[AddrWidth-1:BoundaryLog]
                       == base_addr_r[AddrWidth-1:BoundaryLog]);
      extend_s      = (addr_dout == next_addr_s)
                      && (burst_len_r < max_burst_len)
                      && same_region_s;
   end

   // Output slot handshake; nothing moves while reset is asserted.
   always_comb begin
      write_s    = out_valid_r & burst_full_n & ~rst;
      out_free_s = ~out_valid_r | burst_full_n;
   end

   // Coalescing decision: start, extend, terminate-and-restart, stall, or
   // idle-timeout flush. Defaults hold all state.
   always_comb begin
      read_s       = 1'b0;
      emit_s       = 1'b0;
      base_addr_s  = base_addr_r;
      base_valid_s = base_valid_r;
      burst_len_s  = burst_len_r;
      wait_time_s  = wait_time_r;
      if (addr_empty_n) begin
         if (!base_valid_r) begin
            read_s       = 1'b1;
            base_addr_s  = addr_dout;
            base_valid_s = 1'b1;
            burst_len_s  = {BurstLenWidth{1'b0}};
            wait_time_s  = {WaitTimeWidth{1'b0}};
         end else if (extend_s) begin
            // Merging needs no output slot, so it proceeds under back-pressure.
            read_s      = 1'b1;
            burst_len_s = burst_len_r + {{(BurstLenWidth-1){1'b0}}, 1'b1};
            wait_time_s = {WaitTimeWidth{1'b0}};
         end else if (out_free_s) begin
            read_s      = 1'b1;
            emit_s      = 1'b1;
            base_addr_s = addr_dout;
            burst_len_s = {BurstLenWidth{1'b0}};
            wait_time_s = {WaitTimeWidth{1'b0}};
         end else begin
            read_s = 1'b0;
         end
      end else if (base_valid_r) begin
         if (wait_time_r < max_wait_time) begin
            wait_time_s = wait_time_r + {{(WaitTimeWidth-1){1'b0}}, 1'b1};
         end else if (out_free_s) begin
            emit_s       = 1'b1;
            base_valid_s = 1'b0;
            burst_len_s  = {BurstLenWidth{1'b0}};
            wait_time_s  = {WaitTimeWidth{1'b0}};
         end else begin
            emit_s = 1'b0;
         end
      end else begin
         read_s = 1'b0;
      end
   end

   // Output slot next state: an emit refills the slot even when the current
   // record is being written in the same cycle.
   always_comb begin
      out_valid_s = out_valid_r;
      out_data_s  = out_data_r;
      if (emit_s) begin
         out_valid_s = 1'b1;
         out_data_s  = {burst_len_r, base_addr_r};
      end else if (write_s) begin
         out_valid_s = 1'b0;
      end else begin
         out_valid_s = out_valid_r;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_addr_r  <= {AddrWidth{1'b0}};
         base_valid_r <= 1'b0;
         burst_len_r  <= {BurstLenWidth{1'b0}};
         wait_time_r  <= {WaitTimeWidth{1'b0}};
         out_valid_r  <= 1'b0;
         out_data_r   <= {RecWidth{1'b0}};
      end else begin
         base_addr_r  <= base_addr_s;
         base_valid_r <= base_valid_s;
         burst_len_r  <= burst_len_s;
         wait_time_r  <= wait_time_s;
         out_valid_r  <= out_valid_s;
         out_data_r   <= out_data_s;
      end
   end

   assign addr_read   = read_s & ~rst;
   assign burst_write = write_s;
   assign burst_din   = out_data_r;

`ifdef BURST_COALESCER_STATS_EN
   logic [31:0] stat_bursts_r;
   logic [31:0] stat_beats_r;

   // Statistics counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_bursts_r <= 32'd0;
         stat_beats_r  <= 32'd0;
      end else if (write_s) begin
         stat_bursts_r <= stat_bursts_r + 32'd1;
         stat_beats_r  <= stat_beats_r
                          + {{(32-BurstLenWidth){1'b0}},
                             out_data_r[RecWidth-1 -: BurstLenWidth]}
                          + 32'd1;
      end else begin
         stat_bursts_r <= stat_bursts_r;
         stat_beats_r  <= stat_beats_r;
      end
   end

   assign stat_bursts = stat_bursts_r;
   assign stat_beats  = stat_beats_r;
`else
   // No statistics state in this build.
`endif

endmodule

// File: tb/tb_burst_coalescer.sv
// ---------------------------------------------------------------------------
// tb_burst_coalescer
//
// Directed scoreboard bench: each stimulus step pushes the hand-computed
// {burst_len, base_addr} records it should produce; a negedge monitor pops
// and compares on every burst_write.
// ---------------------------------------------------------------------------
module tb_burst_coalescer;

   localparam int AW  = 64;
   localparam int BLW = 8;
   localparam int WTW = 4;
   localparam int RW  = AW + BLW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [WTW-1:0] max_wait_time = 4'd3;
   logic [BLW-1:0] max_burst_len = 8'd255;
   logic [AW-1:0] addr_dout = 64'd0;
   logic          addr_empty_n = 1'b0;
   logic          addr_read;
   logic [RW-1:0] burst_din;
   logic          burst_full_n = 1'b1;
   logic          burst_write;
`ifdef BURST_COALESCER_STATS_EN
   logic [31:0]   stat_bursts;
   logic [31:0]   stat_beats;
`endif

   burst_coalescer dut (
      .clk           (clk),
      .rst           (rst),
      .max_wait_time (max_wait_time),
      .max_burst_len (max_burst_len),
      .addr_dout     (addr_dout),
      .addr_empty_n  (addr_empty_n),
      .addr_read     (addr_read),
      .burst_din     (burst_din),
      .burst_full_n  (burst_full_n),
      .burst_write   (burst_write)
`ifdef BURST_COALESCER_STATS_EN
      ,
      .stat_bursts   (stat_bursts),
      .stat_beats    (stat_beats)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_read_cyc = 0;
   int last_write_cyc = 0;
   logic [RW-1:0] sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every write must match the oldest expected record.
   always @(negedge clk) begin
      if (burst_write) begin
         last_write_cyc = cyc;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got len=%0d addr=%h, expected none",
                     burst_din[RW-1 -: BLW], burst_din[AW-1:0]);
         end else begin
            logic [RW-1:0] e;
            e = sb.pop_front();
            if (burst_din !== e) begin
               fails++;
               $display("FAIL record: got len=%0d addr=%h, expected len=%0d addr=%h",
                        burst_din[RW-1 -: BLW], burst_din[AW-1:0],
                        e[RW-1 -: BLW], e[AW-1:0]);
            end
         end
      end
   end

   task automatic expect_rec(input logic [BLW-1:0] len, input logic [AW-1:0] a);
      sb.push_back({len, a});
   endtask

   task automatic check(input string name, input logic [RW-1:0] got,
                        input logic [RW-1:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Present one address and wait (bounded) until it is popped.
   task automatic send(input logic [AW-1:0] a, output int waited);
      waited = 0;
      addr_dout = a;
      addr_empty_n = 1'b1;
      @(negedge clk);
      while (!addr_read && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      tests++;
      if (!addr_read) begin
         fails++;
         $display("FAIL read_timeout: address %h not read after %0d cycles", a, waited);
      end
      last_read_cyc = cyc;
      @(posedge clk);
      #1;
      addr_empty_n = 1'b0;
   endtask

   task automatic send_all(input logic [AW-1:0] a);
      int w;
      send(a, w);
   endtask

   // Wait (bounded) for the scoreboard to empty, then idle to catch extras.
   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: %0d records outstanding, expected 0", name, sb.size());
      end
      repeat (12) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_addr_read", RW'(addr_read), RW'(1'b0));
      check("reset_burst_write", RW'(burst_write), RW'(1'b0));
      check("reset_burst_din", burst_din, {RW{1'b0}});
      @(posedge clk);
      #1;

      // Contiguous run: one burst {3, 0x1000}; write at last read + wait + 2
      // (the sixth cycle counting the read cycle itself).
      expect_rec(8'd3, 64'h1000);
      send_all(64'h1000);
      send_all(64'h1040);
      send_all(64'h1080);
      send_all(64'h10C0);
      drain("contig");
      check("contig_latency", RW'(last_write_cyc - last_read_cyc), RW'(5));
`ifdef BURST_COALESCER_STATS_EN
      check("stat_bursts", RW'(stat_bursts), RW'(32'd1));
      check("stat_beats", RW'(stat_beats), RW'(32'd4));
`endif

      // Boundary split at 4 KiB
      expect_rec(8'd0, 64'h0FC0);
      expect_rec(8'd1, 64'h1000);
      send_all(64'h0FC0);
      send_all(64'h1000);
      send_all(64'h1040);
      drain("boundary");

      // Length cap of 2 beats
      max_burst_len = 8'd1;
      expect_rec(8'd1, 64'h0);
      expect_rec(8'd1, 64'h80);
      send_all(64'h0);
      send_all(64'h40);
      send_all(64'h80);
      send_all(64'hC0);
      drain("cap1");

      // Merging disabled
      max_burst_len = 8'd0;
      expect_rec(8'd0, 64'h0);
      expect_rec(8'd0, 64'h40);
      expect_rec(8'd0, 64'h80);
      expect_rec(8'd0, 64'hC0);
      send_all(64'h0);
      send_all(64'h40);
      send_all(64'h80);
      send_all(64'hC0);
      drain("cap0");
      max_burst_len = 8'd255;

      // Address-space wrap never merges
      expect_rec(8'd0, 64'hFFFF_FFFF_FFFF_FFC0);
      expect_rec(8'd0, 64'h0);
      send_all(64'hFFFF_FFFF_FFFF_FFC0);
      send_all(64'h0);
      drain("wrap");

      // Back-pressure: slot holds {0,0x3000}; 0x4040 merges, 0x5000 stalls
      burst_full_n = 1'b0;
      expect_rec(8'd0, 64'h3000);
      expect_rec(8'd1, 64'h4000);
      expect_rec(8'd0, 64'h5000);
      send_all(64'h3000);
      send_all(64'h4000);
      send(64'h4040, w);
      check("bp_merge_no_wait", RW'(w), RW'(0));
      addr_dout = 64'h5000;
      addr_empty_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_stall_addr_read", RW'(addr_read), RW'(1'b0));
      end
      check("bp_pending", RW'(sb.size()), RW'(3));
      @(posedge clk);
      #1;
      burst_full_n = 1'b1;
      @(negedge clk);
      check("bp_release_read", RW'(addr_read), RW'(1'b1));
      @(posedge clk);
      #1;
      addr_empty_n = 1'b0;
      drain("backpressure");

      // Reset mid-burst drops the partial burst
      send_all(64'h6000);
      send_all(64'h6040);
      rst = 1'b1;
      addr_dout = 64'h6080;
      addr_empty_n = 1'b1;
      @(negedge clk);
      check("rst_cycle_addr_read", RW'(addr_read), RW'(1'b0));
      check("rst_cycle_burst_write", RW'(burst_write), RW'(1'b0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      addr_empty_n = 1'b0;
      @(negedge clk);
      check("post_rst_burst_din", burst_din, {RW{1'b0}});
      check("post_rst_burst_write", RW'(burst_write), RW'(1'b0));
      check("post_rst_addr_read", RW'(addr_read), RW'(1'b0));
`ifdef BURST_COALESCER_STATS_EN
      check("post_rst_stat_bursts", RW'(stat_bursts), RW'(32'd0));
`endif
      @(posedge clk);
      #1;
      expect_rec(8'd0, 64'h2000);
      send_all(64'h2000);
      drain("fresh");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
